lsu_mem_ctrl: RTL and testbench

- Load/store sequencer between the core's memory stage and the word-wide, byte-addressed data memory.
- The memory has a combinational read, a posedge write, and only full-word writes, with no byte enables.
- This block accepts byte, halfword and word requests over a valid/ready handshake.
- It performs read-modify-write for sub-word stores, sign- or zero-extends loads, and rejects misaligned or out-of-range accesses without touching memory.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_lane_align.sv | 47 ++++
 rtl/lsu_mem_ctrl.sv | 138 +++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared size encodings, FSM state type and size helper for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } lsu_state_e;

  // Access width in bytes; 0 marks an illegal size code.
  function automatic logic [2:0] size_bytes(input logic [2:0] sz);
    case (sz)
      SZ_B, SZ_BU: size_bytes = 3'd1;
      SZ_H, SZ_HU: size_bytes = 3'd2;
      SZ_W:        size_bytes = 3'd4;
      default:     size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge
// against a little-endian memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_lane)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_load = 32'h0;
    case (i_size)
      SZ_B:    o_load = {{24{w_byte[7]}}, w_byte};
      SZ_BU:   o_load = {24'h0, w_byte};
      SZ_H:    o_load = {{16{w_half[15]}}, w_half};
      SZ_HU:   o_load = {16'h0, w_half};
      SZ_W:    o_load = i_rdata;
      default: o_load = 32'h0;
    endcase

    // Full-word sizes pass the store data straight through.
    o_merged = i_rdata;
    case (i_size)
      SZ_B, SZ_BU: o_merged[8*i_lane +: 8]      = i_wdata[7:0];
      SZ_H, SZ_HU: o_merged[16*i_lane[1] +: 16] = i_wdata[15:0];
      default:     o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: validates requests, does read-modify-write for
// sub-word stores and returns extended load data with a one-cycle response.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_size;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic              r_mem_we;
  logic [31:0]       r_mem_wdata;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

  logic [2:0]        w_nbytes;
  logic [ADDR_W:0]   w_end;
  logic              w_misalign;
  logic              w_req_err;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;

  assign w_nbytes   = size_bytes(req_size);
  assign w_end      = {1'b0, req_addr} + {{(ADDR_W-2){1'b0}}, w_nbytes};
  assign w_misalign = ((w_nbytes == 3'd2) && req_addr[0]) ||
                      ((w_nbytes == 3'd4) && (req_addr[1:0] != 2'b00));
  assign w_req_err  = (w_nbytes == 3'd0) || w_misalign ||
                      (w_end > (ADDR_W+1)'(MEM_BYTES));

  lsu_lane_align u_lane_align (
    .i_size   (r_size),
    .i_lane   (r_addr[1:0]),
    .i_rdata  (mem_rdata),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  assign req_ready = (r_state == IDLE);
  assign mem_addr  = ((r_state == ACCESS) || (r_state == WRITE)) ?
                     {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_size      <= 3'd0;
      r_we        <= 1'b0;
      r_wdata     <= 32'h0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_mem_we    <= 1'b0;
          r_mem_wdata <= 32'h0;
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= 32'h0;
          r_rsp_err   <= 1'b0;
          if (req_valid) begin
            r_addr  <= req_addr;
            r_size  <= req_size;
            r_we    <= req_we;
            r_wdata <= req_wdata;
            if (w_req_err) begin
              r_state     <= DONE;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state <= ACCESS;
              // Word stores write during ACCESS, so arm the strobe now.
              if (req_we && (req_size == SZ_W)) begin
                r_mem_we    <= 1'b1;
                r_mem_wdata <= req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (r_we && (r_size != SZ_W)) begin
            r_state     <= WRITE;
            r_mem_we    <= 1'b1;
            r_mem_wdata <= w_merged;
          end else begin
            r_state     <= DONE;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 32'h0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_we ? 32'h0 : w_load;
          end
        end
        WRITE: begin
          r_state     <= DONE;
          r_mem_we    <= 1'b0;
          r_mem_wdata <= 32'h0;
          r_rsp_valid <= 1'b1;
        end
        DONE: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= 32'h0;
          r_rsp_err   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized and directed bench for lsu_mem_ctrl against a byte-array
// reference model of the data memory.
module tb_lsu_mem_ctrl;

  localparam int MEM_BYTES = 1024;
  localparam int ADDR_W    = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem   [MEM_BYTES/4] = '{default: 32'h0};
  logic [7:0]  ref_b [MEM_BYTES]   = '{default: 8'h0};

  int n_vec = 0;
  int n_err = 0;
  int n_txn = 0;

  lsu_mem_ctrl #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
  endfunction

  function automatic int ref_nbytes(input logic [2:0] sz);
    if (sz == 3'd0 || sz == 3'd4) return 1;
    if (sz == 3'd1 || sz == 3'd5) return 2;
    if (sz == 3'd2) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] sz, input int a);
    logic [15:0] h;
    h = {ref_b[a+1], ref_b[a]};
    case (sz)
      3'd0: return {{24{ref_b[a][7]}}, ref_b[a]};
      3'd4: return {24'h0, ref_b[a]};
      3'd1: return {{16{h[15]}}, h};
      3'd5: return {16'h0, h};
      default: return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
    endcase
  endfunction

  // Stray traffic while busy: must be ignored by the DUT.
  task automatic drive_garbage();
    req_valid = 1'b1;
    req_we    = 1'($urandom_range(0, 1));
    req_size  = 3'($urandom_range(0, 7));
    req_addr  = $urandom_range(0, 127);
    req_wdata = $urandom;
  endtask

  task automatic run_txn(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd);
    int          nb, e_lat, lat, n_we, w;
    logic        e_err, got, rdy_bad, addr_bad;
    logic [31:0] e_rd;

    nb    = ref_nbytes(sz);
    e_err = 1'b0;
    if (nb == 0) e_err = 1'b1;
    else if ((addr % nb) != 0) e_err = 1'b1;
    else if (longint'(addr) + nb > MEM_BYTES) e_err = 1'b1;
    e_rd  = 32'h0;
    if (e_err) e_lat = 1;
    else if (!we) e_lat = 2;
    else if (nb == 4) e_lat = 2;
    else e_lat = 3;
    if (!e_err && !we) e_rd = ref_load(sz, int'(addr));

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = addr; req_wdata = wd;
    w = 0;
    while (!req_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      check_eq("accept_timeout", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    drive_garbage();

    lat = 0; n_we = 0; got = 1'b0; rdy_bad = 1'b0; addr_bad = 1'b0;
    while (!got && lat < 8) begin
      lat++;
      if (mem_we) begin
        n_we++;
        if (mem_addr != {addr[31:2], 2'b00}) addr_bad = 1'b1;
      end
      if (req_ready) rdy_bad = 1'b1;
      if (rsp_valid) got = 1'b1;
      else begin
        drive_garbage();
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      check_eq("rsp_timeout", {31'h0, got}, 32'h1);
      return;
    end

    if (!e_err && we)
      for (int k = 0; k < nb; k++) ref_b[int'(addr) + k] = wd[8*k +: 8];

    check_eq("latency",  lat, e_lat);
    check_eq("rsp_err",  {31'h0, rsp_err}, {31'h0, e_err});
    check_eq("rsp_rdata", rsp_rdata, e_rd);
    check_eq("we_count", n_we, (!e_err && we) ? 1 : 0);
    check_eq("we_addr",  {31'h0, addr_bad}, 32'h0);
    check_eq("busy_ready", {31'h0, rdy_bad}, 32'h0);
    check_eq("done_bus", mem_addr | mem_wdata | {31'h0, mem_we}, 32'h0);
    if (!e_err) check_eq("mem_word", mem[addr[9:2]], ref_word(int'(addr[9:2])));
    n_txn++;
    $display("txn %0d we=%0d sz=%0d addr=%h wd=%h -> err=%0d rdata=%h lat=%0d",
             n_txn, we, sz, addr, wd, rsp_err, rsp_rdata, lat);
  endtask

  task automatic check_after_done();
    @(posedge clk); #1;
    check_eq("post_valid", {31'h0, rsp_valid}, 32'h0);
    check_eq("post_err",   {31'h0, rsp_err}, 32'h0);
    check_eq("post_rdata", rsp_rdata, 32'h0);
  endtask

  initial begin
    logic [2:0]  sz;
    logic [31:0] a;

    #2;
    check_eq("rst_ready", {31'h0, req_ready}, 32'h1);
    check_eq("rst_valid", {31'h0, rsp_valid}, 32'h0);
    check_eq("rst_rsp",   rsp_rdata | {31'h0, rsp_err}, 32'h0);
    check_eq("rst_mem",   mem_addr | mem_wdata | {31'h0, mem_we}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    run_txn(1'b0, 3'd2, 32'h10, 32'h0);
    run_txn(1'b1, 3'd2, 32'h20, 32'h11223344);
    run_txn(1'b1, 3'd0, 32'h22, 32'h000000AA);
    check_eq("sb_word", mem[8], 32'h11AA3344);
    run_txn(1'b0, 3'd0, 32'h22, 32'h0);
    run_txn(1'b0, 3'd4, 32'h22, 32'h0);
    run_txn(1'b1, 3'd1, 32'h32, 32'h00008001);
    check_eq("sh_word", mem[12], 32'h80010000);
    run_txn(1'b0, 3'd1, 32'h32, 32'h0);
    run_txn(1'b0, 3'd5, 32'h32, 32'h0);
    run_txn(1'b0, 3'd2, 32'h13, 32'h0);
    run_txn(1'b0, 3'd1, 32'h21, 32'h0);
    run_txn(1'b0, 3'd3, 32'h20, 32'h0);
    run_txn(1'b1, 3'd2, 32'h3FE, 32'h12345678);
    run_txn(1'b0, 3'd2, 32'h3FC, 32'h0);
    run_txn(1'b1, 3'd1, 32'h3FF, 32'h0);
    check_after_done();

    // Abort a byte store in its write cycle.
    run_txn(1'b1, 3'd2, 32'h40, 32'h55667788);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 3'd0; req_addr = 32'h41; req_wdata = 32'h99;
    while (!req_ready) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_pre_we", {31'h0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_we",    {31'h0, mem_we}, 32'h0);
    check_eq("abort_ready", {31'h0, req_ready}, 32'h1);
    repeat (2) begin
      @(posedge clk); #1;
      check_eq("abort_valid", {31'h0, rsp_valid | mem_we}, 32'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_rel_valid", {31'h0, rsp_valid}, 32'h0);
    check_eq("abort_rel_ready", {31'h0, req_ready}, 32'h1);
    check_eq("abort_word", mem[16], 32'h55667788);

    for (int i = 0; i < 300; i++) begin
      sz = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) :
           3'(($urandom_range(0, 4) < 3) ? $urandom_range(0, 2) : $urandom_range(4, 5));
      a  = ($urandom_range(0, 9) == 0) ? 32'(MEM_BYTES - 8 + $urandom_range(0, 15)) :
           32'($urandom_range(0, 127));
      run_txn(1'($urandom_range(0, 1)), sz, a, $urandom);
    end
    @(negedge clk) req_valid = 1'b0;

    for (int i = 0; i < MEM_BYTES/4; i++) check_eq("final_mem", mem[i], ref_word(i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
